// File: rtl/button_scan_if.sv
// Button-board scan bus: decoder select and shared sense return on the board
// side, debounced button word toward the NES/SNES shifters.
interface button_scan_if;
   logic [2:0] row_sel;
   logic       sense;
   logic       freeze;
   logic [7:0] buttons;
   logic       buttons_valid;

   // Controller side
   modport master (
      output row_sel,
      output buttons,
      output buttons_valid,
      input  sense,
      input  freeze
   );

   // Board / console side
   modport slave (
      input  row_sel,
      input  buttons,
      input  buttons_valid,
      output sense,
      output freeze
   );
endinterface

// File: rtl/button_scan_ctrl.sv
// Button-board scan sequencer: walks the 3-bit decoder select over all eight
// lines, samples the shared sense return, debounces whole 8-bit scans and
// publishes a stable button word, never while a console frame is active.
//
// Output handshake: buttons_valid is a one-cycle strobe with no ready/backpressure.
// It is high exactly in the cycle after buttons was written (buttons and the strobe
// change on the same edge), and fires on every write, changed value or not.
module button_scan_ctrl #(
   parameter int SETTLE_CYCLES  = 16,
   parameter int DEBOUNCE_COUNT = 4
) (
   input  logic                clk,
   input  logic                reset,
   button_scan_if.master       bus,
   output logic [1:0]          state_dbg
);

   typedef enum logic [1:0] {
      SETTLE = 2'd0,
      SAMPLE = 2'd1,
      COMMIT = 2'd2,
      HOLD   = 2'd3
   } state_t;

   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
   localparam logic [3:0] DEB_THRESH  = 4'(DEBOUNCE_COUNT);

   state_t     state_q, state_d;
   logic [7:0] settle_cnt_q, settle_cnt_d;
   logic [2:0] row_sel_q, row_sel_d;
   logic [7:0] raw_q, raw_d;
   logic [7:0] last_raw_q, last_raw_d;
   logic [3:0] stable_cnt_q, stable_cnt_d;
   logic [7:0] buttons_q, buttons_d;
   logic       buttons_valid_q, buttons_valid_d;

   logic       sense_s1_q, sense_s_q;
   logic       freeze_s1_q, freeze_s_q;
   logic [3:0] stable_next;

   // Two-flop synchronizers for the asynchronous sense and freeze inputs
   always_ff @(posedge clk) begin
      if (reset) begin
         sense_s1_q  <= 1'b0;
         sense_s_q   <= 1'b0;
         freeze_s1_q <= 1'b0;
         freeze_s_q  <= 1'b0;
      end else begin
         sense_s1_q  <= bus.sense;
         sense_s_q   <= sense_s1_q;
         freeze_s1_q <= bus.freeze;
         freeze_s_q  <= freeze_s1_q;
      end
   end

   // State register and datapath flops
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= SETTLE;
         settle_cnt_q    <= 8'd0;
         row_sel_q       <= 3'd0;
         raw_q           <= 8'd0;
         last_raw_q      <= 8'd0;
         stable_cnt_q    <= 4'd0;
         buttons_q       <= 8'd0;
         buttons_valid_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         settle_cnt_q    <= settle_cnt_d;
         row_sel_q       <= row_sel_d;
         raw_q           <= raw_d;
         last_raw_q      <= last_raw_d;
         stable_cnt_q    <= stable_cnt_d;
         buttons_q       <= buttons_d;
         buttons_valid_q <= buttons_valid_d;
      end
   end

   // Scan-to-scan agreement count, saturating at 15
   always_comb begin
      stable_next = 4'd1;
      if (raw_q == last_raw_q) begin
         stable_next = (stable_cnt_q == 4'd15) ? 4'd15 : stable_cnt_q + 4'd1;
      end
   end

   // Next-state and datapath updates for the scan sequencer
   always_comb begin
      state_d         = state_q;
      settle_cnt_d    = settle_cnt_q;
      row_sel_d       = row_sel_q;
      raw_d           = raw_q;
      last_raw_d      = last_raw_q;
      stable_cnt_d    = stable_cnt_q;
      buttons_d       = buttons_q;
      buttons_valid_d = 1'b0;

      case (state_q)
         SETTLE: begin
            // Counter stops at its last value; SAMPLE clears it
            if (settle_cnt_q == SETTLE_LAST) begin
               state_d = SAMPLE;
            end else begin
               settle_cnt_d = settle_cnt_q + 8'd1;
            end
         end

         SAMPLE: begin
            raw_d[row_sel_q] = sense_s_q;
            if (row_sel_q != 3'd7) begin
               row_sel_d    = row_sel_q + 3'd1;
               settle_cnt_d = 8'd0;
               state_d      = SETTLE;
            end else begin
               state_d = COMMIT;
            end
         end

         COMMIT: begin
            stable_cnt_d = stable_next;
            last_raw_d   = raw_q;
            if (stable_next >= DEB_THRESH) begin
               if (!freeze_s_q) begin
                  buttons_d       = raw_q;
                  buttons_valid_d = 1'b1;
                  row_sel_d       = 3'd0;
                  settle_cnt_d    = 8'd0;
                  state_d         = SETTLE;
               end else begin
                  // Pending word waits in last_raw until the frame ends
                  state_d = HOLD;
               end
            end else begin
               row_sel_d    = 3'd0;
               settle_cnt_d = 8'd0;
               state_d      = SETTLE;
            end
         end

         HOLD: begin
            if (!freeze_s_q) begin
               buttons_d       = last_raw_q;
               buttons_valid_d = 1'b1;
               row_sel_d       = 3'd0;
               settle_cnt_d    = 8'd0;
               state_d         = SETTLE;
            end
         end

         default: begin
            state_d = SETTLE;
         end
      endcase
   end

   assign bus.row_sel       = row_sel_q;
   assign bus.buttons       = buttons_q;
   assign bus.buttons_valid = buttons_valid_q;
   assign state_dbg         = state_q;

endmodule

// File: tb/tb_button_scan_ctrl.sv
// Directed bench for button_scan_ctrl: a default-parameter instance driven by a
// board model (press mask indexed by row_sel) plus a fast-corner instance.
module tb_button_scan_ctrl;

   localparam logic [1:0] ST_SETTLE = 2'd0;
   localparam logic [1:0] ST_SAMPLE = 2'd1;
   localparam logic [1:0] ST_COMMIT = 2'd2;
   localparam logic [1:0] ST_HOLD   = 2'd3;

   logic       clk;
   logic       reset;
   logic       reset_c;
   logic [7:0] press_mask;
   logic [1:0] state_dbg;
   logic [1:0] state_dbg_c;

   int n_vec;
   int n_err;

   button_scan_if bus ();
   button_scan_if bus_c ();

   // Board model: the shared return is high when the selected line is pressed
   assign bus.sense    = press_mask[bus.row_sel];
   assign bus_c.sense  = 1'b1;
   assign bus_c.freeze = 1'b0;

   button_scan_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   button_scan_ctrl #(.SETTLE_CYCLES(2), .DEBOUNCE_COUNT(1)) dut_c (
      .clk       (clk),
      .reset     (reset_c),
      .bus       (bus_c),
      .state_dbg (state_dbg_c)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Edges until a valid strobe on the selected instance; -1 if budget expires
   task automatic wait_pulse(input bit corner, input int budget, output int n);
      logic v;
      n = -1;
      for (int i = 1; i <= budget; i++) begin
         step();
         v = corner ? bus_c.buttons_valid : bus.buttons_valid;
         if (v) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic wait_state(input logic [1:0] st, input int budget, output bit found);
      found = 1'b0;
      for (int i = 0; i < budget; i++) begin
         step();
         if (state_dbg == st) begin
            found = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      int   n;
      int   commits;
      bit   found;
      bit   early_write;
      bit   bad_row;
      bit   bad_valid;
      bit   bad_buttons;
      int   row_cnt [8];

      n_vec       = 0;
      n_err       = 0;
      reset       = 1'b1;
      reset_c     = 1'b1;
      bus.freeze  = 1'b0;
      press_mask  = 8'h00;
      repeat (3) step();

      // Reset state
      check_val("reset row_sel", 32'(bus.row_sel), 32'h0);
      check_val("reset buttons", 32'(bus.buttons), 32'h00);
      check_val("reset valid", 32'(bus.buttons_valid), 32'h0);
      check_val("reset state", 32'(state_dbg), 32'(ST_SETTLE));

      // Parameter corner: settle 2, debounce 1, every line pressed
      reset_c = 1'b0;
      wait_pulse(1'b1, 100, n);
      check_val("corner pulse edge", 32'(n), 32'd25);
      check_val("corner buttons", 32'(bus_c.buttons), 32'hFF);

      // Clean press on line 5
      press_mask = 8'h20;
      reset      = 1'b0;
      wait_pulse(1'b0, 700, n);
      check_val("press first pulse edge", 32'(n), 32'd548);
      check_val("press buttons", 32'(bus.buttons), 32'h20);

      // Row sweep over one scan starting at the pulse cycle
      for (int r = 0; r < 8; r++) row_cnt[r] = 0;
      bad_row = 1'b0;
      row_cnt[bus.row_sel]++;
      for (int i = 1; i < 137; i++) begin
         step();
         if (32'(bus.row_sel) != i / 17 && !(i >= 136 && bus.row_sel == 3'd7)) bad_row = 1'b1;
         row_cnt[bus.row_sel]++;
      end
      check_val("sweep order", 32'(bad_row), 32'h0);
      for (int r = 0; r < 7; r++) begin
         check_val($sformatf("sweep row %0d cycles", r), 32'(row_cnt[r]), 32'd17);
      end
      check_val("sweep row 7 cycles", 32'(row_cnt[7]), 32'd18);
      step();
      check_val("sweep period pulse", 32'(bus.buttons_valid), 32'h1);
      check_val("sweep row_sel after write", 32'(bus.row_sel), 32'h0);
      wait_pulse(1'b0, 200, n);
      check_val("press period", 32'(n), 32'd137);
      check_val("press buttons repeat", 32'(bus.buttons), 32'h20);

      // Bounce on line 2: alternating for 6 scans, then held
      reset = 1'b1;
      repeat (3) step();
      press_mask  = 8'h04;
      reset       = 1'b0;
      commits     = 0;
      early_write = 1'b0;
      n           = -1;
      for (int i = 1; i <= 2000; i++) begin
         step();
         if (bus.buttons_valid) begin
            n = i;
            break;
         end
         if (bus.buttons != 8'h00) early_write = 1'b1;
         if (state_dbg == ST_COMMIT) begin
            commits++;
            if (commits + 1 <= 6) press_mask = ((commits + 1) % 2 == 1) ? 8'h04 : 8'h00;
            else press_mask = 8'h04;
         end
      end
      check_val("bounce no early write", 32'(early_write), 32'h0);
      check_val("bounce pulse edge", 32'(n), 32'd1370);
      check_val("bounce scans", 32'(commits), 32'd10);
      check_val("bounce buttons", 32'(bus.buttons), 32'h04);

      // Freeze: new word 0x81 qualifies on its 4th scan while the frame is active
      press_mask = 8'h81;
      commits    = 0;
      for (int i = 0; i < 1000 && commits < 3; i++) begin
         step();
         if (state_dbg == ST_COMMIT) commits++;
      end
      bus.freeze = 1'b1;
      wait_state(ST_HOLD, 300, found);
      check_val("freeze enters hold", 32'(found), 32'h1);
      check_val("freeze buttons before hold", 32'(bus.buttons), 32'h04);
      bad_row     = 1'b0;
      bad_valid   = 1'b0;
      bad_buttons = 1'b0;
      for (int i = 0; i < 300; i++) begin
         press_mask = 8'($urandom_range(0, 255));
         step();
         if (bus.row_sel != 3'd7) bad_row = 1'b1;
         if (bus.buttons_valid) bad_valid = 1'b1;
         if (bus.buttons != 8'h04) bad_buttons = 1'b1;
      end
      check_val("hold row_sel stays 7", 32'(bad_row), 32'h0);
      check_val("hold no pulse", 32'(bad_valid), 32'h0);
      check_val("hold buttons unchanged", 32'(bad_buttons), 32'h0);
      press_mask = 8'h81;
      bus.freeze = 1'b0;
      wait_pulse(1'b0, 10, n);
      check_val("unfreeze latency", 32'(n), 32'd3);
      check_val("unfreeze buttons", 32'(bus.buttons), 32'h81);
      check_val("unfreeze row_sel", 32'(bus.row_sel), 32'h0);

      // Reset while in HOLD
      bus.freeze = 1'b1;
      wait_state(ST_HOLD, 300, found);
      check_val("second hold", 32'(found), 32'h1);
      reset     = 1'b1;
      bad_valid = 1'b0;
      repeat (3) begin
         step();
         if (bus.buttons_valid) bad_valid = 1'b1;
      end
      check_val("hold reset row_sel", 32'(bus.row_sel), 32'h0);
      check_val("hold reset buttons", 32'(bus.buttons), 32'h00);
      check_val("hold reset state", 32'(state_dbg), 32'(ST_SETTLE));
      bus.freeze = 1'b0;
      reset      = 1'b0;
      repeat (16) begin
         step();
         if (bus.buttons_valid) bad_valid = 1'b1;
      end
      check_val("reset no pulse", 32'(bad_valid), 32'h0);
      check_val("post reset sample state", 32'(state_dbg), 32'(ST_SAMPLE));
      check_val("post reset row_sel before sample", 32'(bus.row_sel), 32'h0);
      step();
      check_val("post reset row_sel after sample", 32'(bus.row_sel), 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/button_scan_ctrl.md
# button_scan_ctrl

Sequencer for the shared button-board decoder. It steps the 3-bit select of `decoder3_8` through all eight lines and samples the single shared sense return for each line. It debounces the assembled 8-bit vector and presents a stable button word to the NES/SNES parallel-to-serial shifters. Button word updates are held off while a console latch/shift frame is in progress, so a frame never sees a mid-scan change.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 16: clocks the select is held before sampling; legal range 2..255 (covers decoder settle plus 2-flop synchronizer latency).
- `DEBOUNCE_COUNT`, default 4: consecutive identical full scans required before the button word is updated; legal range 1..15.

Ports:
- `clk`  in  1: system clock, single clock domain.
- `reset`  in  1: synchronous, active-high.
- `row_sel`  out  3: drives decoder `a`; selects the board line being scanned.
- `sense`  in  1: shared button return, asynchronous; 1 = pressed.
- `freeze`  in  1: asynchronous; high while a console frame is active (derived from latch). Blocks button word updates.
- `buttons`  out  8: debounced button word; bit n = line n pressed.
- `buttons_valid`  out  1: one-cycle pulse in the cycle `buttons` is written.

## Operation
- **Synchronizers:** `sense` and `freeze` each pass through a 2-flop synchronizer (`sense_s`, `freeze_s`). The FSM uses only the synchronized copies.
- **FSM states:** SETTLE, SAMPLE, COMMIT, HOLD.
- **SETTLE:** `row_sel` is stable. The settle counter counts 0..SETTLE_CYCLES-1, then the FSM goes to SAMPLE.
- **SAMPLE:** one cycle.
  - Writes `raw[row_sel] <= sense_s`.
  - If `row_sel` < 7: `row_sel` increments, settle counter clears, FSM goes to SETTLE.
  - If `row_sel` = 7: FSM goes to COMMIT with `row_sel` held at 7.
- **COMMIT:** one cycle.
  - Compare: if `raw == last_raw`, `stable_cnt` becomes `stable_cnt+1`, saturating at 15; otherwise `stable_cnt` becomes 1.
  - `last_raw <= raw`.
  - Qualify: the new `stable_cnt` must be >= DEBOUNCE_COUNT.
  - Qualified and `freeze_s`=0: `buttons <= raw`, `buttons_valid` = 1, then `row_sel` <= 0 and FSM goes to SETTLE.
  - Qualified and `freeze_s`=1: FSM goes to HOLD. The pending value is kept in `last_raw`.
  - Not qualified: `row_sel` <= 0 and FSM goes to SETTLE, whatever the state of `freeze_s`.
- **HOLD:** scanning is stalled and `row_sel` stays 7. On the first cycle with `freeze_s`=0:
  - `buttons <= last_raw` and `buttons_valid` pulses.
  - `row_sel` <= 0 and FSM goes to SETTLE.
- **No free-running writes:** `buttons` changes only on a COMMIT or HOLD write. `buttons_valid` pulses on every write, including writes where the value is unchanged.
- **Arithmetic:** the settle counter is 8 bits and `stable_cnt` is 4 bits, saturating. There is no wrap-around anywhere. `row_sel` never passes 7; the COMMIT or HOLD exit sets it to 0.

## Timing
- **Reset values:** `row_sel`=0, `buttons`=8'h00, `buttons_valid`=0. Internally `raw`, `last_raw`, `stable_cnt`, the settle counter and all synchronizer flops are 0, and the state is SETTLE.
- **Scan period:** 8·(SETTLE_CYCLES+1)+1 clocks when not held; 137 clocks at the defaults.
- **First update after reset with constant input:** at the end of scan DEBOUNCE_COUNT, i.e. 548 clocks at the defaults.
- **Sample timing:** a line is sampled SETTLE_CYCLES+1 clocks after `row_sel` changes. `sense_s` lags `sense` by 2 clocks.
- **Freeze latency:** the `freeze` rise reaches `freeze_s` 2 clocks later, and the FSM acts on it from that point. When `freeze` falls, HOLD exits 3 clocks later: 2 clocks of synchronizer, then the write at the next edge.
- **Simultaneous events:**
  - `freeze_s` rising in the same cycle as COMMIT: `freeze_s` is sampled in that cycle, so the FSM enters HOLD.
  - Input bounce during HOLD: ignored, because no sampling occurs in HOLD.
- **Reset mid-operation:** reset dominates any state, including HOLD. All outputs return to their reset values on the next edge, and no `buttons_valid` pulse is produced.

## Test plan
- **Reset:** assert `reset` 3 cycles mid-scan in HOLD. Required: `row_sel`=0, `buttons`=00, `buttons_valid`=0, next sample occurs 17 clocks after release.
- **Clean press:** hold line 5 pressed (sense=1 only when `row_sel`=5), `freeze`=0, defaults. Required: first `buttons_valid` pulse at clock 548 with `buttons`=8'h20, then one pulse every 137 clocks.
- **Bounce:** toggle line 2 every other scan for 6 scans, then hold it pressed. Required: `buttons` stays 00 until 4 identical scans complete, then becomes 8'h04.
- **Freeze:** with a qualified value pending, hold `freeze`=1 for 300 clocks. Required: `row_sel` stays 7, no pulse, `buttons` unchanged. After `freeze` falls, a pulse occurs 3 clocks later with the pending value, and `row_sel`=0 on the same edge.
- **Row sweep:** record `row_sel` over one scan. Required: 0..7, each held 17 clocks, then COMMIT, with period 137.
- **Parameter corner:** SETTLE_CYCLES=2 and DEBOUNCE_COUNT=1, all lines pressed. Required: `buttons`=8'hFF with a pulse at the end of the first 25-clock scan.
